// File: rtl/imm_extend_unit.sv
// -----------------------------------------------------------------------------
// imm_extend_unit
//
// Purpose:
//   Immediate extension unit with a one-deep registered output stage. Each
//   accepted request is turned into an OUT_W-bit value according to `mode`
//   (zero/sign extension, upper placement, shift-by-2, address placement,
//   PC-relative branch target). A PREFIX request stores its immediate so that
//   a following ZERO/SIGN request can extend the concatenation
//   {prefix, imm} instead of imm alone.
//
// Handshake (both sides, strict valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. Valid must not depend on ready. Once out_valid is high, out_data and
//   out_err stay unchanged until the edge where out_ready is also high.
//   in_ready = !out_valid || out_ready, so a drain and a new acceptance can
//   happen on the same edge (full throughput).
//
// Ports:
//   clk            in   clock, all state changes on rising edge
//   rst            in   synchronous active-high reset, dominates everything
//   in_valid       in   request valid
//   in_ready       out  request accepted when high together with in_valid
//   mode           in   3-bit operation select (0..7, see MODE_* below)
//   imm            in   IMM_W-bit immediate field
//   addr           in   ADDR_W-bit address field
//   pc             in   OUT_W-bit program counter (BRANCH only)
//   flush          in   drop pending prefix and unconsumed output; wins over
//                       acceptance
//   out_valid      out  result valid
//   out_ready      in   consumer ready
//   out_data       out  OUT_W-bit extended result
//   out_err        out  high for results of the reserved mode 7
//   prefix_pending out  FSM state is HELD (a prefix is stored)
// -----------------------------------------------------------------------------
module imm_extend_unit #(
    parameter int IMM_W  = 6,
    parameter int ADDR_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        mode,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] addr,
    input  logic [OUT_W-1:0]  pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_err,
    output logic              prefix_pending
);

    if (OUT_W < 2 * IMM_W || OUT_W < ADDR_W) begin : g_bad_params
        $error("imm_extend_unit: OUT_W must be >= 2*IMM_W and >= ADDR_W");
    end

    localparam logic [2:0] MODE_ZERO    = 3'd0;
    localparam logic [2:0] MODE_SIGN    = 3'd1;
    localparam logic [2:0] MODE_UPPER   = 3'd2;
    localparam logic [2:0] MODE_SHIFT2  = 3'd3;
    localparam logic [2:0] MODE_ADDR_HI = 3'd4;
    localparam logic [2:0] MODE_BRANCH  = 3'd5;
    localparam logic [2:0] MODE_PREFIX  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t             state_q;
    logic [IMM_W-1:0]   prefix_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_data_q;
    logic               out_err_q;

    logic               accept;
    logic [OUT_W-1:0]   result_d;

    // Extension candidates. Casting a signed operand to a wider size
    // sign-extends it, which also handles OUT_W == 2*IMM_W without a
    // zero-width replication.
    logic [2*IMM_W-1:0] pair_w;
    logic [OUT_W-1:0]   imm_zx;
    logic [OUT_W-1:0]   imm_sx;
    logic [OUT_W-1:0]   pair_zx;
    logic [OUT_W-1:0]   pair_sx;

    assign pair_w  = {prefix_q, imm};
    assign imm_zx  = OUT_W'(imm);
    assign imm_sx  = OUT_W'($signed(imm));
    assign pair_zx = OUT_W'(pair_w);
    assign pair_sx = OUT_W'($signed(pair_w));

    assign in_ready = !out_valid_q || out_ready;
    // flush drops whatever request is presented in the same cycle.
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        result_d = '0;
        case (mode)
            MODE_ZERO:    result_d = (state_q == HELD) ? pair_zx : imm_zx;
            MODE_SIGN:    result_d = (state_q == HELD) ? pair_sx : imm_sx;
            MODE_UPPER:   result_d = imm_zx << (OUT_W - IMM_W);
            MODE_SHIFT2:  result_d = imm_zx << 2;
            MODE_ADDR_HI: result_d = OUT_W'(addr) << (OUT_W - ADDR_W);
            MODE_BRANCH:  result_d = pc + (imm_sx << 1);
            default:      result_d = '0;  // PREFIX produces nothing, 7 is reserved
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prefix_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            prefix_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // Drain first; an acceptance below may refill on the same edge.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (mode == MODE_PREFIX) begin
                    prefix_q <= imm;
                    state_q  <= HELD;
                end else begin
                    // Any stored prefix is consumed (ZERO/SIGN) or discarded.
                    prefix_q    <= '0;
                    state_q     <= IDLE;
                    out_valid_q <= 1'b1;
                    out_data_q  <= result_d;
                    out_err_q   <= (mode == 3'd7);
                end
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_err        = out_err_q;
    assign prefix_pending = (state_q == HELD);

endmodule

// File: tb/tb_imm_extend_unit.sv
module tb_imm_extend_unit;

    localparam int IMM_W  = 6;
    localparam int ADDR_W = 8;
    localparam int OUT_W  = 16;
    localparam int W      = OUT_W + 1;  // {err, data}

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        mode;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_err;
    logic              prefix_pending;

    always #5 clk = ~clk;

    imm_extend_unit #(
        .IMM_W (IMM_W),
        .ADDR_W(ADDR_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mode          (mode),
        .imm           (imm),
        .addr          (addr),
        .pc            (pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_err       (out_err),
        .prefix_pending(prefix_pending)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    bit m_held   = 0;   // a prefix is stored
    int m_prefix = 0;
    bit m_ov     = 0;   // output register holds an unconsumed result

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Result of one non-prefix request, computed with plain integer arithmetic.
    function automatic logic [W-1:0] model(input int md, input int im, input int ad,
                                           input int p, input bit held, input int pre);
        longint m = longint'(1) << OUT_W;
        longint v;
        int     n;
        v = 0;
        case (md)
            0: v = held ? (pre * (2 ** IMM_W) + im) : im;
            1: begin
                n = held ? 2 * IMM_W : IMM_W;
                v = held ? (pre * (2 ** IMM_W) + im) : im;
                if (v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
            end
            2: v = longint'(im) * (longint'(1) << (OUT_W - IMM_W));
            3: v = longint'(im) * 4;
            4: v = longint'(ad) * (longint'(1) << (OUT_W - ADDR_W));
            5: v = longint'(p) + 2 * ((im >= 2 ** (IMM_W - 1)) ? im - 2 ** IMM_W : im);
            7: return {1'b1, {OUT_W{1'b0}}};
            default: v = 0;
        endcase
        v = ((v % m) + m) % m;
        return {1'b0, OUT_W'(v)};
    endfunction

    // ------------------------------------------------------------------
    // Driver: one clock cycle of stimulus. Inputs change 1 unit after the
    // rising edge; acceptance is decided at the falling edge.
    // ------------------------------------------------------------------
    task automatic drive_cycle(input bit vld, input int md, input int im, input int ad,
                               input int p, input bit ordy, input bit fl, input bit r,
                               output bit acc);
        bit ov_n;
        in_valid  = vld;
        mode      = md[2:0];
        imm       = im[IMM_W-1:0];
        addr      = ad[ADDR_W-1:0];
        pc        = p[OUT_W-1:0];
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        acc  = 0;
        ov_n = 0;
        if (r || fl) begin
            m_held   = 0;
            m_prefix = 0;
            exp_q.delete();
        end else begin
            check("in_ready", in_ready, (!m_ov || ordy));
            acc  = vld && (!m_ov || ordy);
            ov_n = m_ov && !ordy;
            if (acc) begin
                if (md == 6) begin
                    m_held   = 1;
                    m_prefix = im;
                end else begin
                    exp_q.push_back(model(md, im, ad, p, m_held, m_prefix));
                    m_held   = 0;
                    m_prefix = 0;
                    ov_n     = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_ov = ov_n;
        check("out_valid", out_valid, ov_n);
        check("prefix_pending", prefix_pending, m_held);
        if (r) begin
            check("rst_out_data", out_data, 0);
            check("rst_out_err", out_err, 0);
            check("rst_in_ready", in_ready, 1);
        end
    endtask

    task automatic send(input int md, input int im, input int ad, input int p);
        bit acc;
        int tries;
        acc   = 0;
        tries = 0;
        while (!acc && tries < 20) begin
            drive_cycle(1, md, im, ad, p, 1, 0, 0, acc);
            tries++;
        end
        if (!acc) check("send_accept_timeout", 0, 1);
    endtask

    task automatic idle(input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++) drive_cycle(0, 0, 0, 0, 0, 1, 0, 0, acc);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops the expected queue on every output handshake and checks
    // that a stalled output stays put.
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0]     e;
        bit               stall_prev;
        logic [OUT_W-1:0] held_data;
        logic             held_err;
        stall_prev = 0;
        held_data  = '0;
        held_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_prev && out_valid) begin
                check("hold_out_data", out_data, held_data);
                check("hold_out_err", out_err, held_err);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got 0x%0h with err %0d, expected no output (t=%0t)",
                             out_data, out_err, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[OUT_W-1:0]);
                    check("out_err", out_err, e[OUT_W]);
                end
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_err   = out_err;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit acc;
        bit vld, fl, r, ordy;
        int md;

        // Reset and reset-state checks
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, acc);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, acc);
        idle(1);

        // Basic extensions of 0x2D
        for (int k = 0; k < 4; k++) send(k, 'h2D, 0, 0);
        send(4, 0, 'hA5, 0);
        send(5, 'h3E, 0, 'h0100);
        send(5, 'h01, 0, 'hFFFE);
        idle(2);

        // Prefix combinations
        send(6, 'h15, 0, 0);
        send(0, 'h2A, 0, 0);
        send(6, 'h3F, 0, 0);
        send(1, 'h00, 0, 0);
        send(6, 'h01, 0, 0);
        send(6, 'h22, 0, 0);       // replaces stored prefix
        send(1, 'h3F, 0, 0);
        send(6, 'h15, 0, 0);
        send(2, 'h2D, 0, 0);       // prefix discarded
        send(0, 'h2A, 0, 0);
        send(7, 'h2D, 'hFF, 'h1234);
        send(0, 'h05, 0, 0);       // error flag clears on next result
        idle(2);

        // Backpressure: back-to-back requests with out_ready low for 3 cycles
        send(3, 'h11, 0, 0);
        for (int k = 0; k < 3; k++) drive_cycle(1, 1, 'h33, 0, 0, 0, 0, 0, acc);
        drive_cycle(1, 1, 'h33, 0, 0, 1, 0, 0, acc);
        check("backpressure_accept", acc, 1);
        idle(2);

        // Flush discards prefix and the request presented with it
        send(6, 'h15, 0, 0);
        drive_cycle(1, 0, 'h2A, 0, 0, 0, 1, 0, acc);
        send(0, 'h2A, 0, 0);
        // Flush drops an unconsumed output
        send(0, 'h07, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, acc);
        idle(1);

        // Reset while a prefix is held
        send(6, 'h15, 0, 0);
        drive_cycle(1, 0, 'h2A, 0, 0, 0, 0, 1, acc);
        send(0, 'h2A, 0, 0);
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            vld  = ($urandom_range(0, 3) != 0);
            md   = ($urandom_range(0, 4) == 0) ? 6 : $urandom_range(0, 7);
            fl   = ($urandom_range(0, 29) == 0);
            r    = ($urandom_range(0, 59) == 0);
            ordy = (fl || r) ? 1'b0 : ($urandom_range(0, 3) != 0);
            drive_cycle(vld, md, $urandom_range(0, 63), $urandom_range(0, 255),
                        $urandom_range(0, 65535), ordy, fl, r, acc);
        end

        idle(4);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 SHALL have parameter IMM_W, default 6, the raw immediate width.
REQ-002 SHALL have parameter ADDR_W, default 8, the address/branch-field width.
REQ-003 SHALL have parameter OUT_W, default 16, the extended result width; OUT_W >= 2*IMM_W and OUT_W >= ADDR_W, elaboration error otherwise.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, request valid.
REQ-007 SHALL have port in_ready, output, 1, request accepted this cycle when high with in_valid.
REQ-008 SHALL have port mode, input, 3, operation select per REQ-015.
REQ-009 SHALL have port imm, input, IMM_W, immediate field.
REQ-010 SHALL have port addr, input, ADDR_W, address field.
REQ-011 SHALL have port pc, input, OUT_W, current program counter, used for BRANCH.
REQ-012 SHALL have port flush, input, 1, discards the pending prefix and any unconsumed output.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, OUT_W), out_err (output, 1), prefix_pending (output, 1).

Function
REQ-014 SHALL accept a request when in_valid && in_ready; in_ready = !out_valid || out_ready (1-deep output register, full-throughput).
REQ-015 SHALL compute per mode: 0 ZERO zero-extend; 1 SIGN sign-extend; 2 UPPER imm in bits [OUT_W-1:OUT_W-IMM_W], rest 0; 3 SHIFT2 zero-extend(imm)<<2; 4 ADDR_HI addr in bits [OUT_W-1:OUT_W-ADDR_W], rest 0; 5 BRANCH pc + (sign-extend(imm)<<1), modulo 2^OUT_W; 6 PREFIX; 7 reserved.
REQ-016 SHALL register the result: out_data/out_valid update on the edge after acceptance (latency 1 cycle).
REQ-017 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL use a two-state FSM: IDLE and HELD; prefix_pending = (state == HELD).
REQ-019 PREFIX accepted: latch imm into prefix_reg, go HELD, produce no output (out_valid unaffected by this request).
REQ-020 PREFIX accepted in HELD: prefix_reg replaced, remain HELD.
REQ-021 ZERO/SIGN accepted in HELD: operand = {prefix_reg, imm} (2*IMM_W bits), extended to OUT_W per mode; return to IDLE.
REQ-022 UPPER/SHIFT2/ADDR_HI/BRANCH accepted in HELD: prefix ignored and discarded; return to IDLE.
REQ-023 Mode 7 accepted: out_valid=1, out_data=0, out_err=1 for that result; state returns to IDLE; out_err=0 for all other results.
REQ-024 flush high: next edge out_valid=0, state IDLE, prefix_reg=0; any request presented that cycle is dropped; flush dominates acceptance.
REQ-025 in_valid low: no state change except output drain by out_ready.
REQ-026 Simultaneous drain and accept (out_valid && out_ready && in_valid): new result replaces old on same edge, out_valid stays 1 (unless PREFIX accepted, then out_valid=0).

Reset
REQ-027 rst high at an edge: out_valid=0, out_data=0, out_err=0, prefix_pending=0, prefix_reg=0, state IDLE; rst dominates flush and acceptance.
REQ-028 in_ready SHALL be 1 in the cycle after reset (output empty).
REQ-029 Reset mid-prefix (HELD) SHALL discard the prefix; the next ZERO uses imm alone.

Verification (IMM_W=6, ADDR_W=8, OUT_W=16)
REQ-030 imm=0x2D through modes 0..3 -> out_data 0x002D, 0xFFED, 0xB400, 0x00B4, each one cycle after acceptance, out_err=0.
REQ-031 ADDR_HI addr=0xA5 -> 0xA500; BRANCH pc=0x0100 imm=0x3E -> 0x00FC; BRANCH pc=0xFFFE imm=0x01 -> 0x0000 (wrap).
REQ-032 PREFIX 0x15 then ZERO 0x2A -> single result 0x056A, prefix_pending 1 then 0; PREFIX 0x3F then SIGN 0x00 -> 0xFFC0.
REQ-033 out_ready=0 for 3 cycles with back-to-back requests -> in_ready=0, out_data held, second request accepted only when out_ready=1; no loss or duplication.
REQ-034 PREFIX 0x15 then flush then ZERO 0x2A -> 0x002A; mode 7 -> out_data 0x0000, out_err=1; rst asserted mid-HELD -> all outputs 0 next cycle.
